// File: rtl/hazard_pkg.sv
// Shared pipeline definitions for the hazard controller: select encodings,
// scoreboard entry layout and the hard-wired zero register.
package hazard_pkg;

   localparam int ADDR_W = 6;

   localparam logic [1:0] BSRC_REG = 2'b00;
   localparam logic [1:0] BSRC_MEM = 2'b10;
   localparam logic [1:0] BSRC_WB  = 2'b11;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   localparam logic [ADDR_W-1:0] REG_ZERO = 6'd0;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] waddr;
      logic              is_load;
   } sb_entry_t;

   localparam int SB_ENTRY_W = $bits(sb_entry_t);

   // EX additionally remembers what it reads, for operand forwarding.
   typedef struct packed {
      sb_entry_t         ent;
      logic [ADDR_W-1:0] src1;
      logic [ADDR_W-1:0] src2;
      logic              use1;
      logic              use2;
   } ex_entry_t;

endpackage

// File: rtl/hazard_match.sv
// Single source/destination comparator; integer r0 never matches.
module hazard_match
   import hazard_pkg::*;
(
   input  logic              valid,
   input  logic              used,
   input  logic [ADDR_W-1:0] src,
   input  logic [ADDR_W-1:0] dst,
   output logic              match
);

   assign match = valid && used && (src == dst) && (src != REG_ZERO);

endmodule

// File: rtl/hazard_ctl.sv
// Interlock/forwarding controller with an EX/MEM/WB destination scoreboard.
// Multi-cycle FPU occupancy of EX is built only with HAZARD_FPU_MULTICYCLE_EN.
module hazard_ctl
   import hazard_pkg::*;
#(
   parameter int FPU_LATENCY = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] DecRs1,
   input  logic [ADDR_W-1:0] DecRs2,
   input  logic              DecUses1,
   input  logic              DecUses2,
   input  logic              DecIsBranch,
   input  logic              DecRegWE,
   input  logic [ADDR_W-1:0] DecRegWAddr,
   input  logic              DecIsLoad,
   input  logic              DecFPMulti,
   output logic              Stall,
   output logic              Bubble,
   output logic [1:0]        BranchSrc,
   output logic [1:0]        ForwardA,
   output logic [1:0]        ForwardB,
   output logic              FPUBusy
);

   localparam int NM = 8;
   // Comparator slots: decode rs1 vs EX/MEM/WB, decode rs2 vs EX,
   // EX src1 vs MEM/WB, EX src2 vs MEM/WB.
   localparam int M_D1_EX = 0, M_D1_MEM = 1, M_D1_WB = 2, M_D2_EX = 3;
   localparam int M_E1_MEM = 4, M_E1_WB = 5, M_E2_MEM = 6, M_E2_WB = 7;

   ex_entry_t ex_q, ex_d;
   sb_entry_t mem_q, mem_d, wb_q, wb_d;

   logic              fpu_busy;
   logic              load_use, branch_stall, stall;
   logic [NM-1:0]     m_valid, m_used, m_hit;
   logic [ADDR_W-1:0] m_src [NM];
   logic [ADDR_W-1:0] m_dst [NM];

   always_comb begin
      m_valid = '0;
      m_used  = '0;
      for (int i = 0; i < NM; i++) begin
         m_src[i] = REG_ZERO;
         m_dst[i] = REG_ZERO;
      end
      m_valid[M_D1_EX]  = ex_q.ent.valid;  m_used[M_D1_EX]  = DecUses1;
      m_src[M_D1_EX]    = DecRs1;          m_dst[M_D1_EX]   = ex_q.ent.waddr;
      m_valid[M_D1_MEM] = mem_q.valid;     m_used[M_D1_MEM] = DecUses1;
      m_src[M_D1_MEM]   = DecRs1;          m_dst[M_D1_MEM]  = mem_q.waddr;
      m_valid[M_D1_WB]  = wb_q.valid;      m_used[M_D1_WB]  = DecUses1;
      m_src[M_D1_WB]    = DecRs1;          m_dst[M_D1_WB]   = wb_q.waddr;
      m_valid[M_D2_EX]  = ex_q.ent.valid;  m_used[M_D2_EX]  = DecUses2;
      m_src[M_D2_EX]    = DecRs2;          m_dst[M_D2_EX]   = ex_q.ent.waddr;
      m_valid[M_E1_MEM] = mem_q.valid;     m_used[M_E1_MEM] = ex_q.use1;
      m_src[M_E1_MEM]   = ex_q.src1;       m_dst[M_E1_MEM]  = mem_q.waddr;
      m_valid[M_E1_WB]  = wb_q.valid;      m_used[M_E1_WB]  = ex_q.use1;
      m_src[M_E1_WB]    = ex_q.src1;       m_dst[M_E1_WB]   = wb_q.waddr;
      m_valid[M_E2_MEM] = mem_q.valid;     m_used[M_E2_MEM] = ex_q.use2;
      m_src[M_E2_MEM]   = ex_q.src2;       m_dst[M_E2_MEM]  = mem_q.waddr;
      m_valid[M_E2_WB]  = wb_q.valid;      m_used[M_E2_WB]  = ex_q.use2;
      m_src[M_E2_WB]    = ex_q.src2;       m_dst[M_E2_WB]   = wb_q.waddr;
   end

   for (genvar g = 0; g < NM; g++) begin : g_match
      hazard_match u_match (
         .valid (m_valid[g]),
         .used  (m_used[g]),
         .src   (m_src[g]),
         .dst   (m_dst[g]),
         .match (m_hit[g])
      );
   end

   always_comb begin
      load_use     = ex_q.ent.is_load && (m_hit[M_D1_EX] || m_hit[M_D2_EX]);
      branch_stall = DecIsBranch &&
                     (m_hit[M_D1_EX] || (m_hit[M_D1_MEM] && mem_q.is_load));
      stall        = load_use || branch_stall || fpu_busy;

      // A MEM hit that survives the branch-stall check is never a load.
      BranchSrc = BSRC_REG;
      if (DecIsBranch && !branch_stall) begin
         if (m_hit[M_D1_MEM])     BranchSrc = BSRC_MEM;
         else if (m_hit[M_D1_WB]) BranchSrc = BSRC_WB;
      end

      ForwardA = FWD_REG;
      if (m_hit[M_E1_MEM])     ForwardA = FWD_MEM;
      else if (m_hit[M_E1_WB]) ForwardA = FWD_WB;

      ForwardB = FWD_REG;
      if (m_hit[M_E2_MEM])     ForwardB = FWD_MEM;
      else if (m_hit[M_E2_WB]) ForwardB = FWD_WB;
   end

   assign Stall   = stall;
   assign Bubble  = stall;
   assign FPUBusy = fpu_busy;

   always_comb begin
      wb_d  = mem_q;
      mem_d = ex_q.ent;
      ex_d  = '0;
      if (fpu_busy) begin
         // EX is held by the FPU op; MEM gets the only bubble.
         ex_d  = ex_q;
         mem_d = '0;
      end else if (!stall) begin
         ex_d.ent.valid   = DecRegWE;
         ex_d.ent.waddr   = DecRegWAddr;
         ex_d.ent.is_load = DecIsLoad;
         ex_d.src1        = DecRs1;
         ex_d.src2        = DecRs2;
         ex_d.use1        = DecUses1;
         ex_d.use2        = DecUses2;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

`ifdef HAZARD_FPU_MULTICYCLE_EN
   localparam int CW = (FPU_LATENCY > 2) ? $clog2(FPU_LATENCY) : 1;

   logic [CW-1:0] busy_cnt_q, busy_cnt_d;

   always_comb begin
      busy_cnt_d = busy_cnt_q;
      if (busy_cnt_q != '0)
         busy_cnt_d = busy_cnt_q - CW'(1);
      else if (!stall && DecFPMulti)
         busy_cnt_d = CW'(FPU_LATENCY - 1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) busy_cnt_q <= '0;
      else       busy_cnt_q <= busy_cnt_d;
   end

   assign fpu_busy = (busy_cnt_q != '0);
`else
   logic unused_fpu_multi;
   assign unused_fpu_multi = DecFPMulti;
   assign fpu_busy         = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctl.sv
// Bench for hazard_ctl: directed hazard scenarios plus random instruction
// streams, checked against a stage-level pipeline model through a scoreboard.
module tb_hazard_ctl;

   localparam int LAT = 4;

   typedef struct packed {
      logic       v;
      logic [5:0] wa;
      logic       ld;
      logic [5:0] s1;
      logic [5:0] s2;
      logic       u1;
      logic       u2;
      logic       br;
      logic       fpm;
   } ins_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] DecRs1 = '0, DecRs2 = '0, DecRegWAddr = '0;
   logic       DecUses1 = 0, DecUses2 = 0, DecIsBranch = 0, DecRegWE = 0;
   logic       DecIsLoad = 0, DecFPMulti = 0;
   logic       Stall, Bubble, FPUBusy;
   logic [1:0] BranchSrc, ForwardA, ForwardB;

   int total = 0;
   int bad = 0;
   logic [8:0] exp_q[$];

   // Instructions resident in EX, MEM, WB as the pipeline sees them.
   ins_t m_ex, m_mem, m_wb;
   int   m_busy;
   ins_t nop_i;

   hazard_ctl #(.FPU_LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .DecRs1(DecRs1), .DecRs2(DecRs2),
      .DecUses1(DecUses1), .DecUses2(DecUses2),
      .DecIsBranch(DecIsBranch), .DecRegWE(DecRegWE),
      .DecRegWAddr(DecRegWAddr), .DecIsLoad(DecIsLoad),
      .DecFPMulti(DecFPMulti),
      .Stall(Stall), .Bubble(Bubble), .BranchSrc(BranchSrc),
      .ForwardA(ForwardA), .ForwardB(ForwardB), .FPUBusy(FPUBusy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, req, $time);
      end
   endtask

   // A source reads what an older instruction writes.
   function automatic bit hit(input logic used, input logic [5:0] src, input ins_t e);
      return e.v && used && (src == e.wa) && (src != 6'd0);
   endfunction

   function automatic logic [1:0] fwd(input logic used, input logic [5:0] src);
      if (hit(used, src, m_mem)) return 2'b01;
      if (hit(used, src, m_wb))  return 2'b10;
      return 2'b00;
   endfunction

   task automatic model_reset();
      m_ex = '0; m_mem = '0; m_wb = '0; m_busy = 0;
   endtask

   task automatic drive(input ins_t d);
      DecRs1 = d.s1; DecRs2 = d.s2; DecUses1 = d.u1; DecUses2 = d.u2;
      DecIsBranch = d.br; DecRegWE = d.v; DecRegWAddr = d.wa;
      DecIsLoad = d.ld; DecFPMulti = d.fpm;
   endtask

   // One cycle: predict outputs for the presented decode slot, then advance.
   task automatic step(input ins_t d, output bit stalled);
      bit lu, bs, busy, st;
      logic [1:0] bsrc;
      lu   = m_ex.ld && (hit(d.u1, d.s1, m_ex) || hit(d.u2, d.s2, m_ex));
      bs   = d.br && (hit(d.u1, d.s1, m_ex) || (m_mem.ld && hit(d.u1, d.s1, m_mem)));
      busy = (m_busy != 0);
      st   = lu || bs || busy;
      bsrc = 2'b00;
      if (d.br && !bs) begin
         if (hit(d.u1, d.s1, m_mem))     bsrc = 2'b10;
         else if (hit(d.u1, d.s1, m_wb)) bsrc = 2'b11;
      end
      exp_q.push_back({st, st, bsrc, fwd(m_ex.u1, m_ex.s1), fwd(m_ex.u2, m_ex.s2), busy});
      @(posedge clk);
      m_wb = m_mem;
      if (busy) begin
         m_mem  = '0;
         m_busy = m_busy - 1;
      end else begin
         m_mem = m_ex;
         m_ex  = st ? nop_i : d;
`ifdef HAZARD_FPU_MULTICYCLE_EN
         if (!st && d.fpm) m_busy = LAT - 1;
`endif
      end
      stalled = st;
      #1;
   endtask

   task automatic issue(input ins_t d);
      bit st;
      int n;
      n = 0;
      drive(d);
      do begin
         step(d, st);
         n++;
      end while (st && n < 20);
      if (st) begin
         total++; bad++;
         $display("FAIL issue_timeout: still stalled after %0d cycles, expected release", n);
      end
      drive(nop_i);
   endtask

   task automatic nops(input int n);
      bit st;
      drive(nop_i);
      for (int i = 0; i < n; i++) step(nop_i, st);
   endtask

   function automatic ins_t mk(input logic we, input logic [5:0] wa, input logic ld,
                               input logic u1, input logic [5:0] s1,
                               input logic u2, input logic [5:0] s2,
                               input logic br, input logic fpm);
      ins_t r;
      r.v = we; r.wa = wa; r.ld = ld; r.u1 = u1; r.s1 = s1;
      r.u2 = u2; r.s2 = s2; r.br = br; r.fpm = fpm;
      return r;
   endfunction

   function automatic logic [5:0] rnd_reg();
      logic [5:0] pool [6];
      pool = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd32, 6'd33};
      return pool[$urandom_range(0, 5)];
   endfunction

   task automatic check_all_zero(input string tag);
      chk({tag, "_stall"}, {1'b0, Stall}, 2'b00);
      chk({tag, "_bubble"}, {1'b0, Bubble}, 2'b00);
      chk({tag, "_bsrc"}, BranchSrc, 2'b00);
      chk({tag, "_fwda"}, ForwardA, 2'b00);
      chk({tag, "_fwdb"}, ForwardB, 2'b00);
      chk({tag, "_busy"}, {1'b0, FPUBusy}, 2'b00);
   endtask

   always @(negedge clk) begin
      logic [8:0] e;
      if (!reset && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("stall", {1'b0, Stall}, {1'b0, e[8]});
         chk("bubble", {1'b0, Bubble}, {1'b0, e[7]});
         chk("branch_src", BranchSrc, e[6:5]);
         chk("forward_a", ForwardA, e[4:3]);
         chk("forward_b", ForwardB, e[2:1]);
         chk("fpu_busy", {1'b0, FPUBusy}, {1'b0, e[0]});
      end
   end

   initial begin
      nop_i = '0;
      model_reset();
      #2;
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Load-use: one stall, then WB forwarding into EX.
      issue(mk(1, 6'd5, 1, 0, 6'd0, 0, 6'd0, 0, 0));
      issue(mk(1, 6'd6, 0, 1, 6'd5, 1, 6'd7, 0, 0));
      nops(3);

      // ALU back-to-back, then with one unrelated instruction between.
      issue(mk(1, 6'd3, 0, 0, 6'd0, 0, 6'd0, 0, 0));
      issue(mk(1, 6'd8, 0, 1, 6'd3, 1, 6'd9, 0, 0));
      nops(3);
      issue(mk(1, 6'd3, 0, 0, 6'd0, 0, 6'd0, 0, 0));
      issue(mk(1, 6'd10, 0, 1, 6'd11, 0, 6'd0, 0, 0));
      issue(mk(1, 6'd8, 0, 0, 6'd0, 1, 6'd3, 0, 0));
      nops(3);

      // Branches on a load result and on an ALU result.
      issue(mk(1, 6'd4, 1, 0, 6'd0, 0, 6'd0, 0, 0));
      issue(mk(0, 6'd0, 0, 1, 6'd4, 0, 6'd0, 1, 0));
      nops(3);
      issue(mk(1, 6'd4, 0, 0, 6'd0, 0, 6'd0, 0, 0));
      issue(mk(0, 6'd0, 0, 1, 6'd4, 0, 6'd0, 1, 0));
      nops(3);

      // r0 immunity versus FP register 32.
      issue(mk(1, 6'd0, 1, 0, 6'd0, 0, 6'd0, 0, 0));
      issue(mk(1, 6'd9, 0, 1, 6'd0, 1, 6'd0, 1, 0));
      nops(3);
      issue(mk(1, 6'd32, 0, 0, 6'd0, 0, 6'd0, 0, 0));
      issue(mk(1, 6'd34, 0, 1, 6'd32, 1, 6'd32, 0, 0));
      nops(3);

      // Multi-cycle FPU op followed by a dependent op.
      issue(mk(1, 6'd33, 0, 1, 6'd35, 0, 6'd0, 0, 1));
      issue(mk(1, 6'd37, 0, 1, 6'd33, 0, 6'd0, 0, 0));
      nops(4);

      // Reset in the middle of FPU occupancy.
      issue(mk(1, 6'd33, 0, 1, 6'd35, 0, 6'd0, 0, 1));
      nops(1);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("mid_reset");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      issue(mk(1, 6'd6, 0, 1, 6'd33, 1, 6'd5, 0, 0));
      nops(3);

      // Random instruction mix over a small register pool.
      for (int i = 0; i < 400; i++) begin
         ins_t r;
         r.br  = ($urandom_range(0, 4) == 0);
         r.ld  = ($urandom_range(0, 3) == 0);
         r.fpm = ($urandom_range(0, 9) == 0);
         r.v   = r.ld || ($urandom_range(0, 4) != 0);
         r.wa  = rnd_reg();
         r.s1  = rnd_reg();
         r.s2  = rnd_reg();
         r.u1  = r.br || ($urandom_range(0, 3) != 0);
         r.u2  = ($urandom_range(0, 1) == 1);
         issue(r);
         if ($urandom_range(0, 5) == 0) nops(1);
      end
      nops(4);

      repeat (2) @(negedge clk);
      #1;
      chk("queue_drained", (exp_q.size() == 0) ? 2'b01 : 2'b00, 2'b01);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
